// File: rtl/freq_pkg.sv
// Shared definitions for the frequency generator / counter pair:
// state encodings, default window geometry and the BCD digit clamp.
package freq_pkg;

    localparam int DEF_UPDATE_PERIOD = 1200;
    localparam int DEF_BITS          = 12;
    localparam int DEF_EDGE_BITS     = 7;
    localparam int MAX_COUNT         = 99;

    // Largest legal BCD digit, derived from the two-digit maximum.
    localparam logic [3:0] BCD_DIGIT_MAX = 4'(MAX_COUNT % 10);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DIVIDE  = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // Digits above 9 are not valid BCD; treat them as 9.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
        return (digit > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : digit;
    endfunction

endpackage

// File: rtl/frequency_generator_if.sv
// Control/status bundle of the frequency generator. The master side
// supplies the BCD digits and load strobe; the slave side returns the
// waveform and the conversion results.
interface frequency_generator_if
    import freq_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int EDGE_BITS = DEF_EDGE_BITS
);
    logic [3:0]           ten_count;
    logic [3:0]           unit_count;
    logic                 load;
    logic                 signal_out;
    logic                 busy;
    logic [EDGE_BITS-1:0] target;
    logic [BITS-1:0]      half_period;

    modport master (
        output ten_count, unit_count, load,
        input  signal_out, busy, target, half_period
    );

    modport slave (
        input  ten_count, unit_count, load,
        output signal_out, busy, target, half_period
    );
endinterface

// File: rtl/period_divider.sv
// Sequential repeated-subtraction divider. i_start loads the operands;
// one subtraction happens per cycle while the remainder still covers
// the divisor. o_done is asserted combinationally in the cycle where the
// remainder has dropped below the divisor, so the caller can take the
// quotient on that same edge.
module period_divider #(
    parameter int BITS          = 12,
    parameter int UPDATE_PERIOD = 1200
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [BITS-1:0] i_dividend,
    input  logic [BITS-1:0] i_divisor,
    output logic [BITS-1:0] o_quotient,
    output logic            o_done
);
    localparam logic [BITS-1:0] QUOT_MAX = BITS'(UPDATE_PERIOD);

    logic            r_active;
    logic [BITS-1:0] r_rem;
    logic [BITS-1:0] r_divisor;
    logic [BITS-1:0] r_quotient;

    // Load operands on start, then subtract once per cycle until done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active   <= 1'b0;
            r_rem      <= '0;
            r_divisor  <= '0;
            r_quotient <= '0;
        end else if (i_abort) begin
            r_active <= 1'b0;
        end else if (i_start) begin
            r_active   <= 1'b1;
            r_rem      <= i_dividend;
            r_divisor  <= i_divisor;
            r_quotient <= '0;
        end else if (r_active) begin
            if (r_rem >= r_divisor) begin
                r_rem <= r_rem - r_divisor;
                if (r_quotient < QUOT_MAX) begin
                    r_quotient <= r_quotient + BITS'(1);
                end
            end else begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_done     = r_active && (r_rem < r_divisor);
    assign o_quotient = r_quotient;

endmodule

// File: rtl/frequency_generator.sv
// Square-wave source producing exactly `target` evenly spaced rising
// edges per UPDATE_PERIOD-clock window. The BCD request is converted to
// binary by repeated addition, the half period is found by the divider,
// and the RUN state toggles the output every half_period clocks until the
// requested edge count for the window is reached.
module frequency_generator
    import freq_pkg::*;
#(
    parameter int UPDATE_PERIOD = DEF_UPDATE_PERIOD,
    parameter int BITS          = DEF_BITS,
    parameter int EDGE_BITS     = DEF_EDGE_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    frequency_generator_if.slave  bus
);
    localparam logic [BITS-1:0] WIN_LAST = BITS'(UPDATE_PERIOD - 1);

    state_t               r_state, w_state_next;
    logic [3:0]           r_tens_left, w_tens_left_next;
    logic [3:0]           r_units, w_units_next;
    logic [EDGE_BITS-1:0] r_target, w_target_next;
    logic [BITS-1:0]      r_half_period, w_half_period_next;
    logic [BITS-1:0]      r_win_cnt, w_win_cnt_next;
    logic [BITS-1:0]      r_ph_cnt, w_ph_cnt_next;
    logic [EDGE_BITS-1:0] r_edges, w_edges_next;
    logic                 r_signal_out, w_signal_out_next;
    logic                 r_busy, w_busy_next;

    logic [EDGE_BITS-1:0] w_target_sum;
    logic [BITS-1:0]      w_divisor;
    logic                 w_div_start;
    logic                 w_div_done;
    logic [BITS-1:0]      w_div_quotient;

    // Final binary target once the tens have been accumulated.
    assign w_target_sum = r_target + EDGE_BITS'(r_units);
    assign w_divisor    = BITS'(w_target_sum) << 1;
    // Divider operands are loaded on the edge that leaves CONVERT, so the
    // first DIVIDE cycle already subtracts. A zero target skips division.
    assign w_div_start  = !bus.load && (r_state == ST_CONVERT) &&
                          (r_tens_left == 4'd0) && (w_target_sum != '0);

    period_divider #(
        .BITS          (BITS),
        .UPDATE_PERIOD (UPDATE_PERIOD)
    ) u_divider (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (w_div_start),
        .i_abort    (bus.load),
        .i_dividend (BITS'(UPDATE_PERIOD)),
        .i_divisor  (w_divisor),
        .o_quotient (w_div_quotient),
        .o_done     (w_div_done)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_tens_left   <= '0;
            r_units       <= '0;
            r_target      <= '0;
            r_half_period <= '0;
            r_win_cnt     <= '0;
            r_ph_cnt      <= '0;
            r_edges       <= '0;
            r_signal_out  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_tens_left   <= w_tens_left_next;
            r_units       <= w_units_next;
            r_target      <= w_target_next;
            r_half_period <= w_half_period_next;
            r_win_cnt     <= w_win_cnt_next;
            r_ph_cnt      <= w_ph_cnt_next;
            r_edges       <= w_edges_next;
            r_signal_out  <= w_signal_out_next;
            r_busy        <= w_busy_next;
        end
    end

    // Next-state logic: load overrides everything, otherwise per-state work.
    always_comb begin
        w_state_next       = r_state;
        w_tens_left_next   = r_tens_left;
        w_units_next       = r_units;
        w_target_next      = r_target;
        w_half_period_next = r_half_period;
        w_win_cnt_next     = r_win_cnt;
        w_ph_cnt_next      = r_ph_cnt;
        w_edges_next       = r_edges;
        w_signal_out_next  = r_signal_out;
        w_busy_next        = r_busy;

        if (bus.load) begin
            w_state_next      = ST_CONVERT;
            w_tens_left_next  = clamp_bcd(bus.ten_count);
            w_units_next      = clamp_bcd(bus.unit_count);
            w_target_next     = '0;
            w_win_cnt_next    = '0;
            w_ph_cnt_next     = '0;
            w_edges_next      = '0;
            w_signal_out_next = 1'b0;
            w_busy_next       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_signal_out_next = 1'b0;
                end
                ST_CONVERT: begin
                    if (r_tens_left != 4'd0) begin
                        w_target_next    = r_target + EDGE_BITS'(10);
                        w_tens_left_next = r_tens_left - 4'd1;
                    end else begin
                        w_target_next = w_target_sum;
                        w_state_next  = ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (r_target == '0) begin
                        w_half_period_next = '0;
                        w_state_next       = ST_RUN;
                        w_busy_next        = 1'b0;
                    end else if (w_div_done) begin
                        w_half_period_next = w_div_quotient;
                        w_state_next       = ST_RUN;
                        w_busy_next        = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_win_cnt == WIN_LAST) begin
                        w_win_cnt_next    = '0;
                        w_ph_cnt_next     = '0;
                        w_edges_next      = '0;
                        w_signal_out_next = 1'b0;
                    end else begin
                        w_win_cnt_next = r_win_cnt + BITS'(1);
                        if (r_target != '0) begin
                            if (r_ph_cnt == r_half_period - BITS'(1)) begin
                                w_ph_cnt_next = '0;
                                if (r_signal_out) begin
                                    w_signal_out_next = 1'b0;
                                end else if (r_edges < r_target) begin
                                    w_signal_out_next = 1'b1;
                                    w_edges_next      = r_edges + EDGE_BITS'(1);
                                end
                            end else begin
                                w_ph_cnt_next = r_ph_cnt + BITS'(1);
                            end
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.signal_out  = r_signal_out;
    assign bus.busy        = r_busy;
    assign bus.target      = r_target;
    assign bus.half_period = r_half_period;

endmodule

// File: tb/tb_frequency_generator.sv
// Directed bench for frequency_generator: a table of BCD requests with
// hand-computed target / half period / busy length, each followed by
// window-by-window edge accounting, plus hand sequences for aborting
// loads and an asynchronous reset in the middle of RUN.
module tb_frequency_generator;

    localparam int UP = 1200;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    frequency_generator_if #(.BITS(12), .EDGE_BITS(7)) bus ();

    frequency_generator #(
        .UPDATE_PERIOD (UP),
        .BITS          (12),
        .EDGE_BITS     (7)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ten;
        logic [3:0] unit;
        int         exp_target;
        int         exp_hp;
        int         exp_busy;
        int         windows;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present digits with a one-cycle load; returns just after the load edge.
    task automatic do_load(input logic [3:0] ten, input logic [3:0] unit);
        bus.ten_count  = ten;
        bus.unit_count = unit;
        bus.load       = 1'b1;
        step();
        bus.load       = 1'b0;
    endtask

    // Count sampled cycles with busy high (bounded).
    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 5000) begin
            cnt++;
            step();
        end
    endtask

    // Observe whole windows starting at the first RUN cycle.
    task automatic run_windows(input int tgt, input int hp, input int nwin, input string tag);
        int   rises;
        int   highs;
        int   first_rise;
        int   last_high;
        int   misplaced;
        logic prev;
        prev = 1'b0;
        for (int w = 0; w < nwin; w++) begin
            rises = 0; highs = 0; first_rise = -1; last_high = -1; misplaced = 0;
            for (int idx = 0; idx < UP; idx++) begin
                if (bus.signal_out === 1'b1) begin
                    highs++;
                    last_high = idx;
                    if (prev !== 1'b1) begin
                        rises++;
                        if (first_rise < 0) first_rise = idx;
                        if (hp != 0 && (idx % (2 * hp)) != hp) misplaced++;
                    end
                end
                prev = bus.signal_out;
                step();
            end
            check({tag, " rises"}, rises, tgt);
            check({tag, " high_cycles"}, highs, tgt * hp);
            check({tag, " misplaced_rises"}, misplaced, 0);
            check({tag, " first_rise"}, first_rise, (tgt != 0) ? hp : -1);
            check({tag, " last_high"}, last_high, (tgt != 0) ? 2 * tgt * hp - 1 : -1);
            $display("window %s #%0d: rises=%0d high=%0d first=%0d last=%0d", tag, w, rises, highs, first_rise, last_high);
        end
    endtask

    initial begin
        int cnt;
        int bad;
        int found;

        n_cmp = 0;
        n_err = 0;
        bus.ten_count  = 4'd0;
        bus.unit_count = 4'd0;
        bus.load       = 1'b0;
        reset_n        = 1'b0;

        //            ten    unit   target hp   busy windows
        vecs[0] = '{4'd2,  4'd3,  23,    26,  30,  2};
        vecs[1] = '{4'd9,  4'd9,  99,    6,   17,  3};
        vecs[2] = '{4'd0,  4'd0,  0,     0,   2,   2};
        vecs[3] = '{4'd12, 4'd15, 99,    6,   17,  1};
        vecs[4] = '{4'd1,  4'd0,  10,    60,  63,  1};
        vecs[5] = '{4'd0,  4'd7,  7,     85,  87,  1};
        vecs[6] = '{4'd0,  4'd1,  1,     600, 602, 1};

        // Reset held for three cycles.
        repeat (3) step();
        check("reset signal_out", int'(bus.signal_out), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset target", int'(bus.target), 0);
        check("reset half_period", int'(bus.half_period), 0);
        reset_n = 1'b1;

        // Two idle windows with no load.
        bad = 0;
        for (int i = 0; i < 2 * UP; i++) begin
            if (bus.signal_out !== 1'b0 || bus.busy !== 1'b0 || bus.target !== 7'd0) bad++;
            step();
        end
        check("idle activity", bad, 0);
        $display("idle: 2 windows, active cycles=%0d", bad);

        // Table-driven requests.
        for (int v = 0; v < 7; v++) begin
            do_load(vecs[v].ten, vecs[v].unit);
            wait_busy(cnt);
            check($sformatf("v%0d busy_cycles", v), cnt, vecs[v].exp_busy);
            check($sformatf("v%0d target", v), int'(bus.target), vecs[v].exp_target);
            check($sformatf("v%0d half_period", v), int'(bus.half_period), vecs[v].exp_hp);
            $display("load (%0d,%0d): busy=%0d target=%0d half_period=%0d", vecs[v].ten, vecs[v].unit,
                     cnt, bus.target, bus.half_period);
            run_windows(vecs[v].exp_target, vecs[v].exp_hp, vecs[v].windows, $sformatf("v%0d", v));
        end

        // Load (5,0), then re-load (0,1) ten cycles into DIVIDE.
        do_load(4'd5, 4'd0);
        repeat (16) step();
        check("abort busy_before", int'(bus.busy), 1);
        do_load(4'd0, 4'd1);
        wait_busy(cnt);
        check("abort busy_cycles", cnt, 602);
        check("abort target", int'(bus.target), 1);
        check("abort half_period", int'(bus.half_period), 600);
        $display("abort in DIVIDE: busy=%0d target=%0d half_period=%0d", cnt, bus.target, bus.half_period);
        run_windows(1, 600, 1, "abort");

        // Load while the single pulse is high: output must drop at once.
        repeat (700) step();
        check("runload high_before", int'(bus.signal_out), 1);
        do_load(4'd0, 4'd0);
        check("runload signal_out", int'(bus.signal_out), 0);
        check("runload busy", int'(bus.busy), 1);
        wait_busy(cnt);
        check("runload busy_cycles", cnt, 2);
        check("runload target", int'(bus.target), 0);
        $display("load during RUN: busy=%0d target=%0d", cnt, bus.target);

        // Asynchronous reset while RUN is driving a high phase.
        do_load(4'd9, 4'd9);
        wait_busy(cnt);
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            if (bus.signal_out === 1'b1) found = 1;
            else step();
        end
        check("rstrun saw_high", found, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("rstrun signal_out", int'(bus.signal_out), 0);
        check("rstrun busy", int'(bus.busy), 0);
        check("rstrun target", int'(bus.target), 0);
        check("rstrun half_period", int'(bus.half_period), 0);
        repeat (2) step();
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.signal_out !== 1'b0 || bus.busy !== 1'b0) bad++;
            step();
        end
        check("rstrun idle_after", bad, 0);
        $display("reset during RUN: idle cycles with activity=%0d", bad);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frequency_generator.md
Name: frequency_generator

Overview:
Stimulus source that is the transmit-side counterpart of frequency_counter. It takes a two-digit BCD edge count (tens, units) and produces a square-wave `signal_out` with exactly that many rising edges in every window of UPDATE_PERIOD clocks. The edges are evenly spaced. It is used on the FPGA as a loop-back source for the counter and as a test-pattern generator.

Parameters:
UPDATE_PERIOD, 1200, window length in clk cycles (the counter's default gate period)
BITS, 12, width of the window, phase and divider counters; must satisfy 2^BITS > UPDATE_PERIOD
EDGE_BITS, 7, width of the binary target and edge counters; holds 0..99

Ports:
clk  input  1  system clock, single clock domain
reset_n  input  1  asynchronous, active-low reset
ten_count  input  4  BCD tens digit; sampled when load=1
unit_count  input  4  BCD units digit; sampled when load=1
load  input  1  one-cycle strobe that latches the digits and (re)starts the generator
signal_out  output  1  generated waveform, registered
busy  output  1  high while converting or dividing, i.e. from the cycle after load until RUN is entered
target  output  EDGE_BITS  binary edge count in use; valid when busy=0
half_period  output  BITS  clocks per output half-cycle; valid when busy=0

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; signal_out=0; busy=0; target=0; half_period=0.
  - All internal counters are 0.
- Digit clamp: any digit above 9 is treated as 9 when latched.
- States: IDLE, CONVERT, DIVIDE, RUN.
- IDLE:
  - signal_out=0.
  - load -> latch the clamped digits, set target=0, go to CONVERT.
- CONVERT (BCD to binary by repeated add):
  - Each cycle with tens_left>0: target += 10, tens_left -= 1.
  - When tens_left==0: target += units, go to DIVIDE.
  - Duration: tens+1 cycles.
- DIVIDE (repeated subtraction):
  - Setup: rem=UPDATE_PERIOD, quotient=0, divisor=2*target.
  - If target==0: half_period=0, go to RUN immediately.
  - Otherwise, each cycle with rem>=divisor: rem -= divisor, quotient += 1.
  - When rem<divisor: half_period=quotient, go to RUN.
- RUN:
  - busy=0.
  - win_cnt counts 0..UPDATE_PERIOD-1, then wraps to 0.
  - On wrap: signal_out<=0, ph_cnt<=0, edges<=0.
  - Otherwise, if target!=0, ph_cnt increments. When ph_cnt==half_period-1:
    - ph_cnt<=0.
    - If signal_out==1: drive 0.
    - If signal_out==0 and edges<target: drive 1 and increment edges.
  - Once edges==target, the output stays low until the wrap.
  - target==0: signal_out stays 0 for the whole window.
  - Spacing:
    - First rising edge is registered half_period cycles after window start.
    - High and low phases are each exactly half_period cycles.
    - Exactly `target` rising edges per window, guaranteed because 2*target*half_period <= UPDATE_PERIOD.
- RUN has no exit except load or reset.
- load in any state, including mid-CONVERT, mid-DIVIDE or mid-RUN:
  - Abort, drive signal_out<=0, re-latch the digits, go to CONVERT.
  - Window and edge counters restart at 0 on the next RUN entry.
- busy timing: busy=1 in the cycle after load and stays 1 through CONVERT and DIVIDE. It falls in the same edge that enters RUN.
- Arithmetic:
  - 2*target is formed at BITS width; max value 198.
  - Quotient saturates at UPDATE_PERIOD; unreachable because target>=1 in DIVIDE.
- Reset asserted mid-operation: everything returns to reset values at once; no glitch beyond the async clear of signal_out.

Decomposition:
- Shared package (freq_pkg):
  - State encodings: IDLE=0, CONVERT=1, DIVIDE=2, RUN=3.
  - MAX_COUNT=99.
  - Defaults UPDATE_PERIOD=1200 and BITS=12, shared with frequency_counter.
- One natural sub-module: period_divider.
  - Sequential repeated-subtraction divider with a start/done handshake.
  - Inputs: dividend, divisor. Outputs: quotient, done.
  - Instantiated for the DIVIDE state; the top level keeps CONVERT, RUN and the window logic.

Test Plan:
- Reset low 3 cycles, then high, no load -> signal_out=0, busy=0 and target=0 for 2 full windows.
- load with ten_count=2, unit_count=3:
  - busy high for 3 CONVERT + 27 DIVIDE cycles.
  - Then target=23 and half_period=26 (1200/46).
  - 23 rising edges per 1200-cycle window; first edge at cycle 26 of the window; each high pulse 26 cycles; output low after cycle 1196 until the wrap.
- ten_count=9, unit_count=9 -> target=99, half_period=6, exactly 99 rising edges in each of 3 consecutive windows.
- ten_count=0, unit_count=0 -> target=0, busy falls after 2 cycles, signal_out stays 0 for 2 windows.
- ten_count=12, unit_count=15 -> clamped to target=99, half_period=6.
- Two interruptions:
  - load (5,0) then, 10 cycles into DIVIDE, load (0,1) -> final target=1, half_period=600, one 600-cycle high pulse per window.
  - reset_n pulsed low mid-RUN -> signal_out=0 immediately and state=IDLE.
